// File: rtl/tlp_tx_arb.sv
// Packet-granular three-source arbiter for the FPGA->CPU TLP transmit pipe.
// Optional per-source EOP counters are enabled with `define TLP_TX_ARB_STATS_EN.
module tlp_tx_arb #(
  parameter int unsigned CMP_PRIORITY = 1,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic [63:0] cmpData_in,
  input  logic        cmpValid_in,
  output logic        cmpReady_out,
  input  logic        cmpSOP_in,
  input  logic        cmpEOP_in,
  input  logic [63:0] f2cData_in,
  input  logic        f2cValid_in,
  output logic        f2cReady_out,
  input  logic        f2cSOP_in,
  input  logic        f2cEOP_in,
  input  logic [63:0] mtrData_in,
  input  logic        mtrValid_in,
  output logic        mtrReady_out,
  input  logic        mtrSOP_in,
  input  logic        mtrEOP_in,
  output logic [63:0] txData_out,
  output logic        txValid_out,
  input  logic        txReady_in,
  output logic        txSOP_out,
  output logic        txEOP_out,
  output logic [1:0]  grant_out,
  output logic        protoErr_out
`ifdef TLP_TX_ARB_STATS_EN
  ,
  output logic [31:0] cmpCount_out,
  output logic [31:0] f2cCount_out,
  output logic [31:0] mtrCount_out
`endif
);

  localparam logic [1:0] GntNone = 2'd0;
  localparam logic [1:0] GntCmp  = 2'd1;
  localparam logic [1:0] GntF2c  = 2'd2;
  localparam logic [1:0] GntMtr  = 2'd3;
  localparam logic [7:0] StarveMax = 8'(STARVE_LIMIT);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  rr_q, rr_d;
  logic [7:0]  starve_q, starve_d;
  logic        first_q, first_d;
  logic        err_q, err_d;

  logic        c_cmp, c_f2c, c_mtr, c_other;
  logic [3:0]  cand;
  logic [1:0]  win, rr_2nd, rr_3rd;
  logic [63:0] sel_data;
  logic        sel_valid, sel_sop, sel_eop, acc;

  function automatic logic [1:0] rr_next(input logic [1:0] src);
    if (CMP_PRIORITY != 0) begin
      return (src == GntF2c) ? GntMtr : GntF2c;
    end
    unique case (src)
      GntCmp:  return GntF2c;
      GntF2c:  return GntMtr;
      default: return GntCmp;
    endcase
  endfunction

  // Arbitration among sources presenting a TLP start.
  always_comb begin
    c_cmp   = cmpValid_in & cmpSOP_in;
    c_f2c   = f2cValid_in & f2cSOP_in;
    c_mtr   = mtrValid_in & mtrSOP_in;
    c_other = c_f2c | c_mtr;
    cand    = {c_mtr, c_f2c, c_cmp, 1'b0};
    rr_2nd  = rr_next(rr_q);
    rr_3rd  = rr_next(rr_2nd);
    win     = GntNone;
    if (CMP_PRIORITY != 0) begin
      if (c_cmp && !((starve_q == StarveMax) && c_other)) begin
        win = GntCmp;
      end else if (c_f2c && c_mtr) begin
        win = rr_q;
      end else if (c_f2c) begin
        win = GntF2c;
      end else if (c_mtr) begin
        win = GntMtr;
      end
    end else begin
      if (cand[rr_q]) begin
        win = rr_q;
      end else if (cand[rr_2nd]) begin
        win = rr_2nd;
      end else if (cand[rr_3rd]) begin
        win = rr_3rd;
      end
    end
  end

  // Pass-through of the granted source; grant_q is non-zero only while busy.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_sop   = 1'b0;
    sel_eop   = 1'b0;
    unique case (grant_q)
      GntCmp: begin
        sel_data = cmpData_in; sel_valid = cmpValid_in;
        sel_sop  = cmpSOP_in;  sel_eop   = cmpEOP_in;
      end
      GntF2c: begin
        sel_data = f2cData_in; sel_valid = f2cValid_in;
        sel_sop  = f2cSOP_in;  sel_eop   = f2cEOP_in;
      end
      GntMtr: begin
        sel_data = mtrData_in; sel_valid = mtrValid_in;
        sel_sop  = mtrSOP_in;  sel_eop   = mtrEOP_in;
      end
      default: ;
    endcase
  end

  assign acc          = sel_valid & txReady_in;
  assign txData_out   = sel_data;
  assign txValid_out  = sel_valid;
  assign txSOP_out    = sel_sop;
  assign txEOP_out    = sel_eop;
  assign cmpReady_out = (grant_q == GntCmp) & txReady_in;
  assign f2cReady_out = (grant_q == GntF2c) & txReady_in;
  assign mtrReady_out = (grant_q == GntMtr) & txReady_in;
  assign grant_out    = grant_q;
  assign protoErr_out = err_q;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    starve_d = starve_q;
    first_d  = first_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (win != GntNone) begin
          state_d = StBusy;
          grant_d = win;
          first_d = 1'b1;
          // In priority mode the pointer only rotates between F2C and MTR.
          if ((CMP_PRIORITY == 0) || (win != GntCmp)) begin
            rr_d = rr_next(win);
          end
          if (win != GntCmp) begin
            starve_d = '0;
          end else if (c_other && (starve_q < StarveMax)) begin
            starve_d = starve_q + 8'd1;
          end
        end
      end
      default: begin
        if (acc) begin
          first_d = 1'b0;
          if (first_q ? !sel_sop : sel_sop) begin
            err_d = 1'b1;
          end
          if (sel_eop) begin
            state_d = StIdle;
            grant_d = GntNone;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q  <= StIdle;
      grant_q  <= GntNone;
      rr_q     <= GntF2c;
      starve_q <= '0;
      first_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      starve_q <= starve_d;
      first_q  <= first_d;
      err_q    <= err_d;
    end
  end

`ifdef TLP_TX_ARB_STATS_EN
  logic [31:0] cmp_cnt_q, f2c_cnt_q, mtr_cnt_q;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      cmp_cnt_q <= '0;
      f2c_cnt_q <= '0;
      mtr_cnt_q <= '0;
    end else if (acc && sel_eop) begin
      if (grant_q == GntCmp) cmp_cnt_q <= cmp_cnt_q + 32'd1;
      if (grant_q == GntF2c) f2c_cnt_q <= f2c_cnt_q + 32'd1;
      if (grant_q == GntMtr) mtr_cnt_q <= mtr_cnt_q + 32'd1;
    end
  end

  assign cmpCount_out = cmp_cnt_q;
  assign f2cCount_out = f2c_cnt_q;
  assign mtrCount_out = mtr_cnt_q;
`endif

endmodule

// File: tb/tb_tlp_tx_arb.sv
// Directed bench for tlp_tx_arb: per-cycle source models driven from one initial block.
module tb_tlp_tx_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] s_data [3];
  logic        s_valid [3];
  logic        s_sop [3];
  logic        s_eop [3];
  logic        s_ready [3];
  logic        tx_ready;
  logic [63:0] tx_data;
  logic        tx_valid, tx_sop, tx_eop, proto_err;
  logic [1:0]  grant;
`ifdef TLP_TX_ARB_STATS_EN
  logic [31:0] cmp_count, f2c_count, mtr_count;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cnt [3];
  int len [3];
  int beat [3];
  int tlpno [3];
  logic sop_force [3];
  int cyc = 0;
  logic [1:0] prev_gnt = 2'd0;
  logic [63:0] tx_log [$];
  int gnt_log [$];
  int gnt_cyc [$];
  int eop_cyc [$];
  int exp_gnt [$];

  always #5 clk = ~clk;

  tlp_tx_arb dut (
    .clk_in      (clk),
    .reset_in    (rst),
    .cmpData_in  (s_data[0]),
    .cmpValid_in (s_valid[0]),
    .cmpReady_out(s_ready[0]),
    .cmpSOP_in   (s_sop[0]),
    .cmpEOP_in   (s_eop[0]),
    .f2cData_in  (s_data[1]),
    .f2cValid_in (s_valid[1]),
    .f2cReady_out(s_ready[1]),
    .f2cSOP_in   (s_sop[1]),
    .f2cEOP_in   (s_eop[1]),
    .mtrData_in  (s_data[2]),
    .mtrValid_in (s_valid[2]),
    .mtrReady_out(s_ready[2]),
    .mtrSOP_in   (s_sop[2]),
    .mtrEOP_in   (s_eop[2]),
    .txData_out  (tx_data),
    .txValid_out (tx_valid),
    .txReady_in  (tx_ready),
    .txSOP_out   (tx_sop),
    .txEOP_out   (tx_eop),
    .grant_out   (grant),
    .protoErr_out(proto_err)
`ifdef TLP_TX_ARB_STATS_EN
    ,
    .cmpCount_out(cmp_count),
    .f2cCount_out(f2c_count),
    .mtrCount_out(mtr_count)
`endif
  );

  function automatic logic [63:0] beat_data(input int s, input int t, input int b);
    return {8'(s + 1), 24'(t), 32'(b)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int s = 0; s < 3; s++) begin
      s_valid[s] = (cnt[s] > 0);
      s_sop[s]   = (beat[s] == 0) || sop_force[s];
      s_eop[s]   = (beat[s] == len[s] - 1);
      s_data[s]  = beat_data(s, tlpno[s], beat[s]);
    end
  endtask

  task automatic start(input int s, input int n, input int l);
    cnt[s] = n; len[s] = l; beat[s] = 0; tlpno[s] = 0;
    drive();
    #1;
  endtask

  // Sample handshakes mid-cycle, advance one clock, then update the source models.
  task automatic cycle();
    logic acc [3];
    for (int s = 0; s < 3; s++) acc[s] = s_valid[s] && s_ready[s];
    if (tx_valid && tx_ready) begin
      tx_log.push_back(tx_data);
      if (tx_eop) eop_cyc.push_back(cyc);
    end
    if (grant != 2'd0 && prev_gnt == 2'd0) begin
      gnt_log.push_back(int'(grant));
      gnt_cyc.push_back(cyc);
    end
    prev_gnt = grant;
    @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      if (acc[s]) begin
        if (beat[s] == len[s] - 1) begin
          beat[s] = 0; cnt[s]--; tlpno[s]++;
        end else begin
          beat[s]++;
        end
      end
    end
    drive();
    cyc++;
    #1;
  endtask

  task automatic clear_logs();
    tx_log.delete(); gnt_log.delete(); gnt_cyc.delete(); eop_cyc.delete();
    prev_gnt = 2'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tx_ready = 1'b1;
    for (int s = 0; s < 3; s++) begin
      cnt[s] = 0; len[s] = 1; beat[s] = 0; tlpno[s] = 0; sop_force[s] = 1'b0;
    end
    drive();
    @(posedge clk);
    #2;
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic run_until_idle(input int maxc, input string tag);
    int k = 0;
    while (((cnt[0] + cnt[1] + cnt[2]) > 0 || grant != 2'd0) && k < maxc) begin
      cycle();
      k++;
    end
    check({tag, "_completes"}, ((cnt[0] + cnt[1] + cnt[2]) > 0 || grant != 2'd0), 1'b0);
  endtask

  initial begin
    do_reset();
    rst = 1'b1;
    #1;
    check("rst_grant", grant, 2'd0);
    check("rst_txvalid", tx_valid, 1'b0);
    check("rst_txdata", tx_data, 64'd0);
    check("rst_txsop_eop", {tx_sop, tx_eop}, 2'b00);
    check("rst_readies", {s_ready[0], s_ready[1], s_ready[2]}, 3'b000);
    check("rst_protoerr", proto_err, 1'b0);
    rst = 1'b0;
    #1;

    // Single 2-beat CMP TLP.
    start(0, 1, 2);
    check("t1_idle_grant", grant, 2'd0);
    check("t1_idle_ready", s_ready[0], 1'b0);
    cycle();
    check("t1_grant", grant, 2'd1);
    check("t1_b0_valid_sop", {tx_valid, tx_sop, tx_eop}, 3'b110);
    check("t1_b0_data", tx_data, beat_data(0, 0, 0));
    check("t1_b0_ready", s_ready[0], 1'b1);
    cycle();
    check("t1_b1_valid_eop", {tx_valid, tx_sop, tx_eop}, 3'b101);
    check("t1_b1_data", tx_data, beat_data(0, 0, 1));
    check("t1_b1_ready", s_ready[0], 1'b1);
    cycle();
    check("t1_end_grant", grant, 2'd0);
    check("t1_end_ready", s_ready[0], 1'b0);
    check("t1_end_valid", tx_valid, 1'b0);

    // 34-beat F2C TLP; CMP SOP shows up while beat 3 is presented.
    clear_logs();
    start(1, 1, 34);
    for (int k = 0; k < 20 && tx_log.size() < 3; k++) cycle();
    check("t2_three_beats", 64'(tx_log.size()), 64'd3);
    start(0, 1, 2);
    run_until_idle(100, "t2");
    check("t2_ngrants", 64'(gnt_log.size()), 64'd2);
    check("t2_first_f2c", 64'(gnt_log[0]), 64'd2);
    check("t2_then_cmp", 64'(gnt_log[1]), 64'd1);
    check("t2_nbeats", 64'(tx_log.size()), 64'd36);
    for (int i = 0; i < 34; i++) check($sformatf("t2_f2c_beat%0d", i), tx_log[i], beat_data(1, 0, i));
    check("t2_cmp_beat0", tx_log[34], beat_data(0, 0, 0));
    check("t2_cmp_beat1", tx_log[35], beat_data(0, 0, 1));
    check("t2_cmp_gap", 64'(gnt_cyc[1]), 64'(eop_cyc[0] + 2));

    // F2C and MTR both pending, CMP idle: strict alternation from F2C.
    do_reset();
    start(1, 3, 2);
    start(2, 3, 2);
    run_until_idle(100, "t3");
    check("t3_ngrants", 64'(gnt_log.size()), 64'd6);
    for (int i = 0; i < 6; i++) check($sformatf("t3_grant%0d", i), 64'(gnt_log[i]), (i % 2 == 0) ? 64'd2 : 64'd3);

    // CMP flood with F2C waiting: 8 CMP, 1 F2C, 8 CMP, 1 F2C, 4 CMP, 1 F2C.
    do_reset();
    start(0, 20, 1);
    start(1, 3, 1);
    run_until_idle(200, "t4");
    exp_gnt.delete();
    for (int i = 0; i < 8; i++) exp_gnt.push_back(1);
    exp_gnt.push_back(2);
    for (int i = 0; i < 8; i++) exp_gnt.push_back(1);
    exp_gnt.push_back(2);
    for (int i = 0; i < 4; i++) exp_gnt.push_back(1);
    exp_gnt.push_back(2);
    check("t4_ngrants", 64'(gnt_log.size()), 64'd23);
    for (int i = 0; i < 23; i++) check($sformatf("t4_grant%0d", i), 64'(gnt_log[i]), 64'(exp_gnt[i]));

    // Backpressure for 5 cycles mid-packet, then a stray SOP on beat 3.
    do_reset();
    start(1, 1, 6);
    cycle();
    cycle();
    cycle();
    tx_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t5_stall%0d_valid", i), tx_valid, 1'b1);
      check($sformatf("t5_stall%0d_data", i), tx_data, beat_data(1, 0, 2));
      check($sformatf("t5_stall%0d_ready", i), {s_ready[0], s_ready[1], s_ready[2]}, 3'b000);
      cycle();
    end
    tx_ready = 1'b1;
    #1;
    check("t5_resume_ready", s_ready[1], 1'b1);
    check("t5_no_err_yet", proto_err, 1'b0);
    cycle();
    sop_force[1] = 1'b1;
    drive();
    #1;
    check("t5_sop_passthru", tx_sop, 1'b1);
    cycle();
    sop_force[1] = 1'b0;
    drive();
    #1;
    check("t5_err_set", proto_err, 1'b1);
    run_until_idle(20, "t5");
    check("t5_err_sticky", proto_err, 1'b1);
    check("t5_nbeats", 64'(tx_log.size()), 64'd6);
    check("t5_beat5", tx_log[5], beat_data(1, 0, 5));

    // Reset asserted mid F2C TLP.
    do_reset();
    check("t6_err_cleared", proto_err, 1'b0);
    start(1, 1, 10);
    cycle();
    cycle();
    cycle();
    check("t6_busy_grant", grant, 2'd2);
    rst = 1'b1;
    #1;
    check("t6_rst_grant", grant, 2'd0);
    check("t6_rst_valid", tx_valid, 1'b0);
    check("t6_rst_ready", s_ready[1], 1'b0);
    cnt[1] = 0;
    drive();
    cycle();
    rst = 1'b0;
    cycle();
    check("t6_after_grant", grant, 2'd0);

`ifdef TLP_TX_ARB_STATS_EN
    do_reset();
    start(0, 3, 2);
    start(1, 2, 2);
    run_until_idle(100, "t7");
    check("t7_cmp_count", cmp_count, 32'd3);
    check("t7_f2c_count", f2c_count, 32'd2);
    check("t7_mtr_count", mtr_count, 32'd0);
    rst = 1'b1;
    #1;
    check("t7_rst_counts", {cmp_count, f2c_count, mtr_count}, 96'd0);
    rst = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
